// File: rtl/shift_issue_if.sv
// shift_issue_if: upstream, downstream and shifter-side signals of the shift issue stage.
interface shift_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] sh_src;
  logic [4:0]  sh_amt;
  logic [2:0]  sh_op;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  modport master (
    output in_valid, in_inst, in_rs1_val, in_rs2_val, out_ready, sh_out,
    input  in_ready, sh_src, sh_amt, sh_op, out_valid, out_result, out_rd, out_we, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_rs1_val, in_rs2_val, out_ready, sh_out,
    output in_ready, sh_src, sh_amt, sh_op, out_valid, out_result, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes RV32I shifts into barrel-shifter controls and registers the result.
module shift_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_issue_if.slave     bus,
  output logic [CNT_W-1:0] retired_cnt
);
  logic            dec_valid_q, wb_valid_q, w_adv, d_adv, accept, is_r, is_i;
  logic [XLEN-1:0] dec_src_q, wb_result_q;
  logic [4:0]      dec_amt_q, dec_rd_q, wb_rd_q, dec_amt_d;
  logic [2:0]      dec_op_q, dec_op_d;
  logic            dec_ill_q, wb_we_q, wb_ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic            unused;
  assign unused = ^{bus.in_inst[19:15], bus.in_rs2_val[XLEN-1:5]};
  always_comb begin
    is_r = bus.in_inst[6:0] == 7'b0110011;
    is_i = bus.in_inst[6:0] == 7'b0010011;
    dec_op_d = {3{is_r | is_i}} & {
      bus.in_inst[31:25] == 7'b0000000 && bus.in_inst[14:12] == 3'b001,
      bus.in_inst[31:25] == 7'b0000000 && bus.in_inst[14:12] == 3'b101,
      bus.in_inst[31:25] == 7'b0100000 && bus.in_inst[14:12] == 3'b101};
    dec_amt_d = (dec_op_d == 3'b000) ? 5'd0 : is_r ? bus.in_rs2_val[4:0] : bus.in_inst[24:20];
  end
  assign w_adv           = !wb_valid_q | bus.out_ready;
  assign d_adv           = dec_valid_q & w_adv;
  assign bus.in_ready    = !dec_valid_q | w_adv;
  assign accept          = bus.in_valid & bus.in_ready;
  assign bus.sh_src      = dec_src_q;
  assign bus.sh_amt      = dec_amt_q;
  assign bus.sh_op       = dec_op_q;
  assign bus.out_valid   = wb_valid_q;
  assign bus.out_result  = wb_result_q;
  assign bus.out_rd      = wb_rd_q;
  assign bus.out_we      = wb_we_q;
  assign bus.out_illegal = wb_ill_q;
  assign retired_cnt     = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      dec_src_q   <= '0;
      dec_amt_q   <= '0;
      dec_op_q    <= '0;
      dec_rd_q    <= '0;
      dec_ill_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_ill_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (flush) begin
        dec_valid_q <= 1'b0;
        wb_valid_q  <= 1'b0;
      end else begin
        if (accept) begin
          dec_valid_q <= 1'b1;
          dec_src_q   <= bus.in_rs1_val;
          dec_amt_q   <= dec_amt_d;
          dec_op_q    <= dec_op_d;
          dec_rd_q    <= bus.in_inst[11:7];
          dec_ill_q   <= dec_op_d == 3'b000;
        end else if (d_adv) dec_valid_q <= 1'b0;
        // W drains and refills from D on the same edge, so no bubble under full throughput
        if (d_adv) begin
          wb_valid_q  <= 1'b1;
          wb_result_q <= dec_ill_q ? '0 : bus.sh_out;
          wb_rd_q     <= dec_rd_q;
          wb_we_q     <= !dec_ill_q && dec_rd_q != 5'd0;
          wb_ill_q    <= dec_ill_q;
        end else if (bus.out_ready) wb_valid_q <= 1'b0;
      end
      if (bus.out_valid && bus.out_ready && !wb_ill_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed shift vectors with a queue scoreboard checked by a separate monitor.
module tb_shift_issue_stage;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 0, rst_n = 0, flush = 0;
  logic [31:0] retired_cnt;
  exp_t        sb[$];
  exp_t        got;
  int          checks = 0, errors = 0;
  logic [31:0] s_inst[8], s_rs1[8], s_rs2[8], s_res[8];

  shift_issue_if bus();
  shift_issue_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .retired_cnt(retired_cnt));

  always #5 clk = ~clk;

  always_comb
    bus.sh_out = bus.sh_op[2] ? bus.sh_src << bus.sh_amt :
                 bus.sh_op[1] ? bus.sh_src >> bus.sh_amt :
                 bus.sh_op[0] ? 32'($signed(bus.sh_src) >>> bus.sh_amt) : 32'h0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic exp_t mk(logic [31:0] res, logic [4:0] rd, logic we, logic ill);
    return '{res: res, rd: rd, we: we, ill: ill};
  endfunction

  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got result %h rd %0d want nothing", bus.out_result, bus.out_rd);
      end else begin
        got = sb.pop_front();
        chk("out_result", bus.out_result, got.res);
        chk("out_rd", 32'(bus.out_rd), 32'(got.rd));
        chk("out_we", 32'(bus.out_we), 32'(got.we));
        chk("out_illegal", 32'(bus.out_illegal), 32'(got.ill));
      end
    end

  task automatic send(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                      input exp_t e, input logic must_accept);
    bus.in_valid   = 1'b1;
    bus.in_inst    = inst;
    bus.in_rs1_val = rs1;
    bus.in_rs2_val = rs2;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (must_accept) chk("in_ready_stream", 32'(bus.in_ready), 32'd1);
      if (bus.in_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout got in_ready 0 want 1");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_we", 32'(bus.out_we), 32'd0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_retired_cnt", retired_cnt, 32'd0);
    chk("rst_sh_src", bus.sh_src, 32'd0);
    chk("rst_sh_amt", 32'(bus.sh_amt), 32'd0);
    chk("rst_sh_op", 32'(bus.sh_op), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_inst = 0; bus.in_rs1_val = 0; bus.in_rs2_val = 0; bus.out_ready = 0;
    s_inst[0] = enc(7'h00, 5'd8,  5'd6, 3'b001, 5'd1, 7'h13); s_rs1[0] = 32'h000000FF; s_rs2[0] = 32'hFFFFFFFF; s_res[0] = 32'h0000FF00;
    s_inst[1] = enc(7'h00, 5'd4,  5'd6, 3'b101, 5'd2, 7'h13); s_rs1[1] = 32'h12345678; s_rs2[1] = 32'hFFFFFFFF; s_res[1] = 32'h01234567;
    s_inst[2] = enc(7'h20, 5'd16, 5'd6, 3'b101, 5'd3, 7'h13); s_rs1[2] = 32'h87654321; s_rs2[2] = 32'hFFFFFFFF; s_res[2] = 32'hFFFF8765;
    s_inst[3] = enc(7'h00, 5'd3,  5'd2, 3'b001, 5'd4, 7'h33); s_rs1[3] = 32'h0F0F0F0F; s_rs2[3] = 32'h00000024; s_res[3] = 32'hF0F0F0F0;
    s_inst[4] = enc(7'h00, 5'd3,  5'd2, 3'b101, 5'd5, 7'h33); s_rs1[4] = 32'h80000000; s_rs2[4] = 32'h0000001F; s_res[4] = 32'h00000001;
    s_inst[5] = enc(7'h20, 5'd3,  5'd2, 3'b101, 5'd6, 7'h33); s_rs1[5] = 32'hDEADBEEF; s_rs2[5] = 32'h00000040; s_res[5] = 32'hDEADBEEF;
    s_inst[6] = enc(7'h00, 5'd31, 5'd6, 3'b001, 5'd7, 7'h13); s_rs1[6] = 32'h00000003; s_rs2[6] = 32'hFFFFFFFF; s_res[6] = 32'h80000000;
    s_inst[7] = enc(7'h20, 5'd1,  5'd6, 3'b101, 5'd8, 7'h13); s_rs1[7] = 32'h7FFFFFFE; s_rs2[7] = 32'hFFFFFFFF; s_res[7] = 32'h3FFFFFFF;

    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(posedge clk); #1;
    rst_n = 1;

    // basic register and immediate forms
    bus.out_ready = 1;
    send(32'h003110B3, 32'h00000001, 32'h0000003F, mk(32'h80000000, 5'd1, 1'b1, 1'b0), 1'b0);
    @(negedge clk);
    chk("sll_sh_op", 32'(bus.sh_op), 32'b100);
    chk("sll_sh_amt", 32'(bus.sh_amt), 32'd31);
    chk("sll_sh_src", bus.sh_src, 32'h00000001);
    @(posedge clk); #1;
    send(32'h40435293, 32'h80000000, 32'h0, mk(32'hF8000000, 5'd5, 1'b1, 1'b0), 1'b0);
    @(negedge clk);
    chk("srai_sh_op", 32'(bus.sh_op), 32'b001);
    chk("srai_sh_amt", 32'(bus.sh_amt), 32'd4);
    @(posedge clk); #1;
    send(32'h00435293, 32'h80000000, 32'h0, mk(32'h08000000, 5'd5, 1'b1, 1'b0), 1'b0);
    drain();
    chk("cnt_after_basic", retired_cnt, 32'd3);

    // back-to-back stream
    for (int i = 0; i < 8; i++)
      send(s_inst[i], s_rs1[i], s_rs2[i], mk(s_res[i], 5'(i + 1), 1'b1, 1'b0), 1'b1);
    drain();
    chk("cnt_after_stream", retired_cnt, 32'd11);

    // illegal encodings and rd==x0
    send(32'h00000033, 32'h5, 32'h5, mk(32'h0, 5'd0, 1'b0, 1'b1), 1'b0);
    @(negedge clk);
    chk("illegal_sh_op", 32'(bus.sh_op), 32'd0);
    chk("illegal_sh_amt", 32'(bus.sh_amt), 32'd0);
    @(posedge clk); #1;
    send(enc(7'h20, 5'd3, 5'd2, 3'b001, 5'd9, 7'h33), 32'h5, 32'h3, mk(32'h0, 5'd9, 1'b0, 1'b1), 1'b0);
    send(enc(7'h00, 5'd5, 5'd6, 3'b001, 5'd0, 7'h13), 32'h1, 32'h0, mk(32'h20, 5'd0, 1'b0, 1'b0), 1'b0);
    drain();
    chk("cnt_after_illegal", retired_cnt, 32'd12);

    // back-pressure: two entries held, outputs stable
    bus.out_ready = 0;
    send(enc(7'h00, 5'd2, 5'd6, 3'b001, 5'd10, 7'h13), 32'h5, 32'h0, mk(32'h14, 5'd10, 1'b1, 1'b0), 1'b0);
    send(enc(7'h00, 5'd1, 5'd6, 3'b101, 5'd11, 7'h13), 32'h100, 32'h0, mk(32'h80, 5'd11, 1'b1, 1'b0), 1'b0);
    bus.in_valid = 1; bus.in_inst = 32'h003110B3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_result", bus.out_result, 32'h14);
      chk("bp_out_rd", 32'(bus.out_rd), 32'd10);
      chk("bp_d_src", bus.sh_src, 32'h100);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    drain();
    chk("cnt_after_bp", retired_cnt, 32'd14);

    // flush with D and W full and a new instruction offered
    bus.out_ready = 0;
    send(enc(7'h00, 5'd1, 5'd6, 3'b001, 5'd12, 7'h13), 32'h1, 32'h0, mk(32'h2, 5'd12, 1'b1, 1'b0), 1'b0);
    send(enc(7'h00, 5'd1, 5'd6, 3'b001, 5'd13, 7'h13), 32'h2, 32'h0, mk(32'h4, 5'd13, 1'b1, 1'b0), 1'b0);
    bus.in_valid = 1; bus.in_inst = enc(7'h00, 5'd1, 5'd6, 3'b001, 5'd14, 7'h13); bus.in_rs1_val = 32'h3;
    flush = 1;
    @(posedge clk); #1;
    flush = 0; bus.in_valid = 0;
    sb.delete();
    bus.out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    // flush with an empty pipe must also drop the offered instruction
    @(posedge clk); #1;
    bus.in_valid = 1; flush = 1;
    @(posedge clk); #1;
    bus.in_valid = 0; flush = 0;
    repeat (4) begin
      @(negedge clk);
      chk("flush_quiet", 32'(bus.out_valid), 32'd0);
    end
    chk("cnt_after_flush", retired_cnt, 32'd14);

    // reset with entries in flight
    @(posedge clk); #1;
    send(s_inst[0], s_rs1[0], s_rs2[0], mk(s_res[0], 5'd1, 1'b1, 1'b0), 1'b0);
    send(s_inst[1], s_rs1[1], s_rs2[1], mk(s_res[1], 5'd2, 1'b1, 1'b0), 1'b0);
    rst_n = 0;
    sb.delete();
    @(posedge clk); #1;
    check_reset();
    @(posedge clk); #1;
    rst_n = 1;
    send(s_inst[2], s_rs1[2], s_rs2[2], mk(s_res[2], 5'd3, 1'b1, 1'b0), 1'b0);
    drain();
    chk("cnt_after_reset", retired_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
